// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default frame geometry.
package uart_pkg;

    // Receiver FSM states; BREAK holds off new frames while the line stays low after a framing error.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops; both start at 1 so a reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start/data/stop framing, LSB first, no parity,
// with a one-deep output register handed to the consumer over valid/ready.
//
// Output handshake: dout is held stable while rx_valid=1; a byte is consumed on
// any clock edge where rx_valid=1 and rx_ready=1. A frame completing while the
// held byte is unconsumed (and not being consumed in that same cycle) is dropped
// and reported with a one-cycle overrun pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output state_t               state_dbg
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state logic: frame FSM advances only on os_tick; handshake clears valid every cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        if (os_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        cnt_d   = '0;
                    end
                end
                ST_START: begin
                    // Mid start bit: a high line here was a glitch, not a frame.
                    if (cnt_q == HALF_LAST) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_d = '0;
                        if (rx_s) begin
                            state_d = ST_IDLE;
                            if (!valid_q || rx_ready) begin
                                dout_d  = shift_q;
                                valid_d = 1'b1;
                            end else begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // All receiver state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout      = dout_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serial frames driven bit by bit, received bytes
// checked against an expected queue, pulse outputs tallied by a monitor.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int DW       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic          clk;
    logic          reset;
    logic          os_tick;
    logic          rx;
    logic          rx_ready;
    logic [DW-1:0] dout;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;
    state_t        state_dbg;

    int check_cnt   = 0;
    int err_cnt     = 0;
    int load_cnt    = 0;
    int valid_cyc   = 0;
    int ferr_cyc    = 0;
    int ovr_cyc     = 0;
    int busy_cyc    = 0;
    int tick_num    = 0;

    logic [DW-1:0] exp_q[$];

    uart_rx #(
        .DATA_BITS  (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .os_tick   (os_tick),
        .rx        (rx),
        .dout      (dout),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample strobe: one clk wide, every TICK_DIV clocks
    initial begin
        os_tick = 1'b0;
        forever begin
            repeat (TICK_DIV - 1) @(negedge clk);
            os_tick = 1'b1;
            tick_num++;
            @(negedge clk);
            os_tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        check_cnt++;
        assert (got === want) else begin
            err_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Monitor: detects each new byte landing in dout and compares it with the queue head
    initial begin : monitor
        logic          prev_valid;
        logic          hs;
        logic [DW-1:0] want;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            hs = prev_valid && rx_ready;
            #1;
            if (frame_err) ferr_cyc++;
            if (overrun)   ovr_cyc++;
            if (busy)      busy_cyc++;
            if (rx_valid)  valid_cyc++;
            if (rx_valid && (!prev_valid || hs)) begin
                load_cnt++;
                want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                check("dout_on_load", dout, want);
                check("busy_low_on_load", busy, 0);
            end
            prev_valid = rx_valid;
        end
    end

    task automatic idle_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic b, input int nbits);
        rx = b;
        repeat (nbits * BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic stop_bit);
        send_bits(1'b0, 1);
        for (int i = 0; i < DW; i++) send_bits(data[i], 1);
        send_bits(stop_bit, 1);
    endtask

    // Raises rx_ready for exactly the clock edge on which the stop bit is sampled
    task automatic ready_at_stop();
        bit seen;
        int k;
        seen = 1'b0;
        for (int g = 0; g < 4000 && !seen; g++) begin
            @(negedge clk);
            #1;
            if (state_dbg == ST_STOP) seen = 1'b1;
        end
        check("stop_state_reached", seen, 1);
        if (seen) begin
            k = tick_num + OS;
            for (int g = 0; g < 200 && tick_num < k; g++) begin
                @(negedge clk);
                #1;
            end
            rx_ready = 1'b1;
            @(negedge clk);
            #1;
            rx_ready = 1'b0;
        end
    endtask

    // Watchdog
    initial begin
        #1ms;
        err_cnt++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int l0;
        int f0;
        int o0;
        int v0;
        logic [DW-1:0] partial;

        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        idle_clks(4);

        // Reset state
        check("rst_dout", dout, 0);
        check("rst_valid", rx_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, ST_IDLE);
        reset = 1'b0;
        idle_clks(2 * BIT_CLKS);

        // Good frame 0xA5
        l0 = load_cnt; v0 = valid_cyc; f0 = ferr_cyc;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle_clks(BIT_CLKS);
        check("a5_load_count", load_cnt - l0, 1);
        check("a5_valid_cycles", valid_cyc - v0, 1);
        check("a5_no_frame_err", ferr_cyc - f0, 0);
        check("a5_valid_low_after", rx_valid, 0);

        // False start: line low for 4 ticks
        l0 = load_cnt; busy_cyc = 0;
        rx = 1'b0;
        idle_clks(4 * TICK_DIV);
        rx = 1'b1;
        idle_clks(2 * BIT_CLKS);
        check("false_start_busy_cycles", busy_cyc, 8 * TICK_DIV);
        check("false_start_no_load", load_cnt - l0, 0);
        check("false_start_idle", state_dbg, ST_IDLE);

        // Framing error on 0x3C, line held low, then 0x55
        l0 = load_cnt; f0 = ferr_cyc;
        send_frame(8'h3C, 1'b0);
        send_bits(1'b0, 3);
        check("break_state_while_low", state_dbg, ST_BREAK);
        check("break_busy_while_low", busy, 1);
        rx = 1'b1;
        idle_clks(2 * BIT_CLKS);
        check("ferr_pulse_count", ferr_cyc - f0, 1);
        check("ferr_no_load", load_cnt - l0, 0);
        check("ferr_back_to_idle", state_dbg, ST_IDLE);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle_clks(BIT_CLKS);
        check("after_break_load", load_cnt - l0, 1);

        // Overrun: 0x11 then 0x22 back to back, consumer stalled
        rx_ready = 1'b0;
        o0 = ovr_cyc; l0 = load_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle_clks(BIT_CLKS);
        check("ovr_pulse_count", ovr_cyc - o0, 1);
        check("ovr_dout_kept", dout, 8'h11);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_single_load", load_cnt - l0, 1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        check("ovr_valid_cleared", rx_valid, 0);
        idle_clks(BIT_CLKS);

        // Handshake coincident with acceptance of 0x22
        o0 = ovr_cyc; l0 = load_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle_clks(BIT_CLKS);
        check("same_cycle_first_held", dout, 8'h11);
        exp_q.push_back(8'h22);
        fork
            send_frame(8'h22, 1'b1);
            ready_at_stop();
        join
        idle_clks(BIT_CLKS);
        check("same_cycle_dout", dout, 8'h22);
        check("same_cycle_valid", rx_valid, 1);
        check("same_cycle_no_overrun", ovr_cyc - o0, 0);
        check("same_cycle_loads", load_cnt - l0, 2);
        rx_ready = 1'b1;
        idle_clks(4);
        check("same_cycle_drained", rx_valid, 0);
        idle_clks(BIT_CLKS);

        // Reset during data bit 4, then 0xF0
        l0 = load_cnt; f0 = ferr_cyc; o0 = ovr_cyc;
        partial = 8'h9A;
        send_bits(1'b0, 1);
        for (int i = 0; i < 4; i++) send_bits(partial[i], 1);
        rx = partial[4];
        idle_clks(BIT_CLKS / 2);
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        check("midrst_dout", dout, 0);
        check("midrst_valid", rx_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_state", state_dbg, ST_IDLE);
        idle_clks(3);
        reset = 1'b0;
        idle_clks(2 * BIT_CLKS);
        check("midrst_no_load", load_cnt - l0, 0);
        check("midrst_no_ferr", ferr_cyc - f0, 0);
        check("midrst_no_ovr", ovr_cyc - o0, 0);
        exp_q.push_back(8'hF0);
        send_frame(8'hF0, 1'b1);
        idle_clks(BIT_CLKS);
        check("f0_load", load_cnt - l0, 1);

        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 16: os_tick pulses per bit period; even, >= 4.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 os_tick  input  1  one-clk-wide strobe at OVERSAMPLE x baud rate.
REQ-006 rx  input  1  serial line, idle high, asynchronous to clk.
REQ-007 dout  output  DATA_BITS  last accepted byte; stable while rx_valid=1.
REQ-008 rx_valid  output  1  dout holds an unconsumed byte.
REQ-009 rx_ready  input  1  consumer accepts dout when rx_valid=1 and rx_ready=1 in the same cycle.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-011 overrun  output  1  one-cycle pulse: frame completed while rx_valid=1 and rx_ready=0.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer whose flops reset to 1; all decisions use the synchronized value rx_s.
REQ-014 Frame format SHALL be 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1); no parity.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, STOP and BREAK; the FSM and the tick counter advance only on cycles with os_tick=1.
REQ-016 IDLE: on os_tick with rx_s=0 -> START, tick counter cleared.
REQ-017 START: after OVERSAMPLE/2 ticks, sample rx_s; 0 -> DATA with counter and bit index cleared; 1 -> IDLE as a false start with no output activity.
REQ-018 DATA: every OVERSAMPLE ticks, sample rx_s and shift it into the MSB of the shift register (right shift); after DATA_BITS samples -> STOP.
REQ-019 STOP: after OVERSAMPLE ticks, sample rx_s; 1 -> frame accepted, -> IDLE; 0 -> frame_err pulse, data discarded, -> BREAK.
REQ-020 BREAK: remain until rx_s=1 on an os_tick, then -> IDLE; no new frame starts while the line stays low.
REQ-021 On acceptance with rx_valid=0, or with rx_valid=1 and rx_ready=1 in the same cycle: dout <= shift register and rx_valid=1 in the next cycle; overrun stays 0.
REQ-022 On acceptance with rx_valid=1 and rx_ready=0: the new byte is dropped, dout is unchanged, and overrun pulses for one cycle.
REQ-023 rx_valid SHALL clear in the cycle after a handshake, unless REQ-021 reloads it in that same cycle.
REQ-024 Sampling latency: rx edge to rx_s is 2 clk cycles; stop-bit sample to rx_valid=1 is 1 clk cycle.
REQ-025 The tick counter SHALL be ceil(log2(OVERSAMPLE)) bits wide and the bit index ceil(log2(DATA_BITS+1)) bits wide; neither wraps mid-bit.

Reset
REQ-026 Reset SHALL force state=IDLE, counter=0, bit index=0, shift register=0, dout=0, rx_valid=0, frame_err=0, overrun=0, busy=0, and synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no output pulse; after release, reception resumes at the next falling edge of rx_s.

Structure
REQ-028 Shared package uart_pkg SHALL hold the FSM state encoding and the default DATA_BITS and OVERSAMPLE constants.
REQ-029 The 2-flop synchronizer SHALL be the sub-module uart_rx_sync (ports clk, reset, d, q; reset value 1).
REQ-030 os_tick generation lies outside this block.

Verification (OVERSAMPLE=16, DATA_BITS=8, rx_ready=1 unless noted)
REQ-031 Frame 0xA5 with a valid stop bit -> dout=0xA5, rx_valid pulses 1 cycle, frame_err=0, busy falls after the stop sample.
REQ-032 rx low for 4 ticks then high -> no rx_valid, state returns to IDLE, busy high for 8 ticks.
REQ-033 Frame 0x3C with stop bit = 0, line held low 3 bit times -> one frame_err pulse, no rx_valid, no new frame until rx returns high; a following frame 0x55 is received correctly.
REQ-034 Frames 0x11 then 0x22 back-to-back with rx_ready=0 -> dout=0x11, rx_valid stays 1, one overrun pulse; after rx_ready=1 for 1 cycle, rx_valid=0.
REQ-035 Handshake in the same cycle as the 0x22 acceptance -> dout=0x22, rx_valid=1, no overrun.
REQ-036 Reset asserted at data bit 4 of a frame -> all outputs reach their reset values immediately; the next frame 0xF0 is received correctly.
